// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch/decode decoupling queue: default width, RV NOP encoding
// and the per-cycle queue operation used to update occupancy.
package fetch_queue_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] RV_NOP       = 32'h00000013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    FQ_OP_IDLE = 2'b00,
    FQ_OP_PUSH = 2'b01,
    FQ_OP_POP  = 2'b10,
    FQ_OP_BOTH = 2'b11
  } fq_op_e;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: DEPTH x (2*XLEN) registers, one synchronous write port
// and one asynchronous read port. Contents are deliberately not reset.
module fetch_queue_mem #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                wr_en_i,
  input  logic [PTR_W-1:0]    wr_ptr_i,
  input  logic [2*XLEN-1:0]   wr_data_i,
  input  logic [PTR_W-1:0]    rd_ptr_i,
  output logic [2*XLEN-1:0]   rd_data_o
);

  logic [2*XLEN-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_i];

endmodule : fetch_queue_mem

// File: rtl/fetch_queue.sv
// Fetch-to-decode FIFO of {pc, instr} pairs with flush on redirect and pause = !in_ready.
// Optional FETCH_QUEUE_BYPASS_EN: empty-queue pass-through with 0-cycle latency.
//
// Handshakes: a transfer happens on a port exactly in a cycle where its valid and ready
// are both high at the rising clock edge; in_ready never looks at out_ready, and out_valid
// is masked during flush/reset so decode sees no transfer in those cycles.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEFAULT,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_instr,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_instr,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [2*XLEN-1:0] rd_data;
  logic              empty, full, bypass, push, pop;
  fq_op_e            op;

  fetch_queue_mem #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clock     (clock),
    .wr_en_i   (push),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i ({in_pc, in_instr}),
    .rd_ptr_i  (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  always_comb begin
    empty  = (count_q == '0);
    full   = (count_q == FULL_CNT);
    bypass = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: hand the fetched pair straight to decode without storing it.
    bypass = empty & in_valid & out_ready & ~flush & ~reset;
`endif
    in_ready  = ~full & ~reset;
    out_valid = (~empty & ~flush & ~reset) | bypass;
    push      = in_valid & in_ready & ~flush & ~bypass;
    pop       = out_valid & out_ready & ~bypass;
    op        = fq_op_e'({pop, push});

    if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end else if (out_valid) begin
      out_pc    = rd_data[2*XLEN-1:XLEN];
      out_instr = rd_data[XLEN-1:0];
    end else begin
      out_pc    = '0;
      out_instr = XLEN'(RV_NOP);
    end
    count = count_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (reset | flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      unique case (op)
        FQ_OP_PUSH: begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
        end
        FQ_OP_POP: begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          count_d  = count_q - 1'b1;
        end
        FQ_OP_BOTH: begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic checked each cycle
// against a queue-based reference model.
module tb_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic            clock = 1'b0;
  logic            reset, flush, in_valid, out_ready;
  logic [XLEN-1:0] in_pc, in_instr;
  logic            in_ready, out_valid;
  logic [XLEN-1:0] out_pc, out_instr;
  logic [2:0]      count;

  int checks   = 0;
  int failures = 0;

  logic [2*XLEN-1:0] exp_q[$];

  always #5 clock = ~clock;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
    reset = rst; flush = fl; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
  endtask

  // Check outputs mid-cycle against the model, then advance the model over the clock edge.
  task automatic step(input string tag);
    int    sz;
    logic  byp, e_ov, e_ir, do_push, do_pop;
    logic [31:0] e_pc, e_ins;
    #4;
    sz  = exp_q.size();
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (sz == 0) && in_valid && out_ready && !flush && !reset;
`endif
    e_ir = (sz != DEPTH) && !reset;
    e_ov = ((sz != 0) && !flush && !reset) || byp;
    if (byp) begin
      e_pc = in_pc; e_ins = in_instr;
    end else if (e_ov) begin
      e_pc = exp_q[0][63:32]; e_ins = exp_q[0][31:0];
    end else begin
      e_pc = '0; e_ins = NOP;
    end
    check({tag, ".count"},     32'(count),     32'(sz));
    check({tag, ".in_ready"},  32'(in_ready),  32'(e_ir));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    check({tag, ".out_pc"},    out_pc,         e_pc);
    check({tag, ".out_instr"}, out_instr,      e_ins);
    @(posedge clock);
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      do_push = in_valid && (sz != DEPTH) && !byp;
      do_pop  = e_ov && out_ready && !byp;
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({in_pc, in_instr});
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    step("rst"); step("rst");

    // Fill to full with decode stalled, then try a fifth push.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 32'(i * 4), $urandom, 0);
      step("fill");
    end
    drive(0, 0, 1, 32'h10, $urandom, 0);
    step("full_ignore");
    check("full.count_is_4", 32'(count), 32'd4);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      step("drain");
    end
    drive(0, 0, 0, 0, 0, 1);
    step("drained");

    // Streaming: one entry per cycle with pointer wrap.
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 32'h200 + 32'(i * 4), $urandom, 1);
      step("stream");
    end
    drive(0, 0, 0, 0, 0, 0);
    step("stream_tail");
    drive(0, 0, 0, 0, 0, 1);
    step("stream_drain");

    // Flush at count=3 with a simultaneous push.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 32'h300 + 32'(i * 4), $urandom, 0);
      step("pre_flush");
    end
    drive(0, 1, 1, 32'h30c, $urandom, 1);
    step("flush");
    drive(0, 0, 0, 0, 0, 1);
    step("post_flush");

    // Reset at count=2 during push+pop.
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 32'h400 + 32'(i * 4), $urandom, 0);
      step("pre_rst");
    end
    drive(1, 0, 1, 32'h408, $urandom, 1);
    step("mid_rst");
    drive(0, 0, 0, 0, 0, 0);
    step("post_rst");

    // Bypass-style pattern: empty queue, fetch and decode both ready.
    drive(0, 0, 1, 32'h100, 32'hcafe0013, 1);
    step("empty_in_out");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 6),
            ($urandom_range(0, 99) < 65), $urandom, $urandom,
            ($urandom_range(0, 99) < 55));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_queue
